// File: rtl/line_clear_engine_if.sv
// Handshake and field bus between the game FSM (master) and line_clear_engine (slave).
interface line_clear_engine_if #(
  parameter int FIELD_W = 10,
  parameter int FIELD_H = 20,
  parameter int CELL_W  = 3,
  parameter int CNT_W   = $clog2(FIELD_H + 1)
);
  logic                                start;
  logic [FIELD_H*FIELD_W*CELL_W-1:0]   f_in;
  logic [7:0]                          level;
  logic                                busy;
  logic                                done;
  logic [FIELD_H*FIELD_W*CELL_W-1:0]   f_out;
  logic [CNT_W-1:0]                    lines_cleared;
  logic [FIELD_H-1:0]                  row_mask;
  logic [15:0]                         score_delta;

  modport master (
    output start, f_in, level,
    input  busy, done, f_out, lines_cleared, row_mask, score_delta
  );

  modport slave (
    input  start, f_in, level,
    output busy, done, f_out, lines_cleared, row_mask, score_delta
  );
endinterface

// File: rtl/line_clear_engine.sv
// Snapshot-and-compact line clearer: one bottom-up pass with separate read/write row pointers.
// Optional scoring is enabled by defining LINE_CLEAR_SCORE_EN.
module line_clear_engine #(
  parameter int FIELD_W    = 10,
  parameter int FIELD_H    = 20,
  parameter int CELL_W     = 3,
  parameter int EMPTY_CODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  line_clear_engine_if.slave bus
);
  localparam int CNT_W = $clog2(FIELD_H + 1);
  localparam int PTR_W = $clog2(FIELD_H);
  localparam int ROW_W = FIELD_W * CELL_W;
  localparam int FLD_W = FIELD_H * ROW_W;
  localparam logic [CELL_W-1:0] EMPTY_CELL = CELL_W'(EMPTY_CODE);
  localparam logic [ROW_W-1:0]  EMPTY_ROW  = {FIELD_W{EMPTY_CELL}};

  typedef enum logic [1:0] {IDLE, SCAN, FILL} state_t;

  function automatic logic row_full(input logic [ROW_W-1:0] row);
    row_full = 1'b1;
    for (int c = 0; c < FIELD_W; c++)
      if (row[c*CELL_W +: CELL_W] == EMPTY_CELL) row_full = 1'b0;
  endfunction

`ifdef LINE_CLEAR_SCORE_EN
  function automatic logic [15:0] score_sat(input logic [CNT_W-1:0] n, input logic [7:0] lvl);
    logic [18:0] base;
    logic [18:0] prod;
    case (n)
      CNT_W'(0): base = 19'd0;
      CNT_W'(1): base = 19'd100;
      CNT_W'(2): base = 19'd300;
      CNT_W'(3): base = 19'd500;
      default:   base = 19'd800;
    endcase
    prod = base * (19'(lvl) + 19'd1);
    score_sat = (prod > 19'd65535) ? 16'hFFFF : prod[15:0];
  endfunction
`endif

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   src_q, dst_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [FIELD_H-1:0] mask_q;
  logic [ROW_W-1:0]   work_q [FIELD_H];

  logic               busy_q, done_q;
  logic [FLD_W-1:0]   f_out_q;
  logic [CNT_W-1:0]   lines_q;
  logic [FIELD_H-1:0] row_mask_q;
  logic [FLD_W-1:0]   fill_field;
  logic               accept;
  logic               src_full;

  assign accept   = (state_q == IDLE) && bus.start;
  assign src_full = row_full(work_q[src_q]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SCAN;
      SCAN:    if (src_q == '0) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // After the scan the kept rows sit at the bottom; the top cnt_q rows are stale and become empty.
  always_comb begin
    fill_field = '0;
    for (int r = 0; r < FIELD_H; r++)
      fill_field[r*ROW_W +: ROW_W] = (CNT_W'(r) < cnt_q) ? EMPTY_ROW : work_q[r];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      f_out_q    <= {FIELD_H{EMPTY_ROW}};
      lines_q    <= '0;
      row_mask_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          src_q  <= PTR_W'(FIELD_H - 1);
          dst_q  <= PTR_W'(FIELD_H - 1);
          cnt_q  <= '0;
          mask_q <= '0;
          busy_q <= 1'b1;
        end
        SCAN: begin
          src_q <= src_q - PTR_W'(1);
          if (src_full) begin
            mask_q[src_q] <= 1'b1;
            cnt_q         <= cnt_q + CNT_W'(1);
          end else begin
            dst_q <= dst_q - PTR_W'(1);
          end
        end
        FILL: begin
          f_out_q    <= fill_field;
          lines_q    <= cnt_q;
          row_mask_q <= mask_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Work buffer is pure data: no reset, overwritten by every accepted snapshot.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < FIELD_H; r++)
        work_q[r] <= bus.f_in[r*ROW_W +: ROW_W];
    end else if (state_q == SCAN && !src_full) begin
      work_q[dst_q] <= work_q[src_q];
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  score_q <= 16'd0;
    else if (state_q == FILL) score_q <= score_sat(cnt_q, bus.level);
  end
  assign bus.score_delta = score_q;
`else
  logic unused_level;
  assign unused_level    = ^bus.level;
  assign bus.score_delta = 16'd0;
`endif

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.f_out         = f_out_q;
  assign bus.lines_cleared = lines_q;
  assign bus.row_mask      = row_mask_q;
endmodule
